// File: rtl/front_panel_pkg.sv
// Shared types and constants for the front-panel encoder event path.
package front_panel_pkg;

    typedef struct packed {
        logic switch;
        logic clockwise;
        logic click;
    } enc_event_t;

    localparam int unsigned EVT_CLICK = 0;
    localparam int unsigned EVT_CW    = 1;
    localparam int unsigned EVT_SW    = 2;
    localparam int unsigned EVT_VALID = 3;
    localparam int unsigned EVT_OVF   = 4;

    localparam int unsigned STEP_SLOW = 1;
    localparam int unsigned STEP_FAST = 4;

endpackage

// File: rtl/enc_event_fifo.sv
// Synchronous FIFO with a registered head word that already reflects the
// entry at the head on the clock after a push into an empty queue.
module enc_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_en, pop_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = head_q;

    // A pop frees a slot, so a push at full is still accepted when paired with a pop.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        // New head is the slot being written this cycle: bypass the memory.
        if (wr_ptr_d != rd_ptr_d) begin
            if (push_en && (rd_ptr_d == wr_ptr_q)) head_d = wdata;
            else                                   head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/encoder_event_buffer.sv
// Rotary-encoder event queue, overflow flag and saturating detent position.
// Optional step acceleration is enabled by defining ENC_ACCEL_EN.
module encoder_event_buffer
    import front_panel_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned ACCEL_WINDOW = 250000
) (
    input  logic                     clk,
    input  logic                     spi_reset_n,
    input  logic                     enc_state_change_stb,
    input  logic                     click,
    input  logic                     clockwise,
    input  logic                     switch,
    input  logic                     event_rd_stb,
    input  logic                     pos_clr_stb,
    output logic [7:0]               event_reg,
    output logic [CNT_W-1:0]         position,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned EW = CNT_W + 3;
    localparam logic signed [EW-1:0] POS_MAX = {4'b0000, {(CNT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] POS_MIN = {4'b1111, {(CNT_W-1){1'b0}}};

    enc_event_t       evt_in;
    logic [2:0]       head;
    logic             fifo_full, fifo_empty;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] position_q, position_d;
    logic             step_en;
    logic [EW-1:0]    step_mag;
    logic signed [EW-1:0] pos_ext, step_e, sum;

    assign evt_in = '{switch: switch, clockwise: clockwise, click: click};

    enc_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (spi_reset_n),
        .push  (enc_state_change_stb),
        .wdata (evt_in),
        .pop   (event_rd_stb),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A fresh overflow outranks the clear from a pop in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (event_rd_stb && !fifo_empty)                      ovf_d = 1'b0;
        if (enc_state_change_stb && fifo_full && !event_rd_stb) ovf_d = 1'b1;
    end

    assign event_reg = {3'b000, ovf_q, ~fifo_empty, head};
    assign position  = position_q;
    assign step_en   = enc_state_change_stb && click;

`ifdef ENC_ACCEL_EN
    localparam int unsigned TW = $clog2(ACCEL_WINDOW + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          have_prev_q, prev_cw_q;
    logic          fast;

    assign fast = have_prev_q && (timer_q < TW'(ACCEL_WINDOW)) && (prev_cw_q == clockwise);

    always_comb begin
        timer_d = timer_q;
        if (step_en)                         timer_d = '0;
        else if (timer_q < TW'(ACCEL_WINDOW)) timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!spi_reset_n) begin
            timer_q     <= '0;
            have_prev_q <= 1'b0;
            prev_cw_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            if (step_en) begin
                have_prev_q <= 1'b1;
                prev_cw_q   <= clockwise;
            end
        end
    end
`endif

    always_comb begin
        step_mag = EW'(STEP_SLOW);
`ifdef ENC_ACCEL_EN
        if (fast) step_mag = EW'(STEP_FAST);
`endif
        step_e  = clockwise ? step_mag : -step_mag;
        pos_ext = {{3{position_q[CNT_W-1]}}, position_q};
        sum     = pos_ext + step_e;
        if (sum > POS_MAX)      sum = POS_MAX;
        else if (sum < POS_MIN) sum = POS_MIN;

        position_d = position_q;
        if (pos_clr_stb)  position_d = '0;
        else if (step_en) position_d = sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!spi_reset_n) begin
            ovf_q      <= 1'b0;
            position_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            position_q <= position_d;
        end
    end

endmodule

// File: tb/tb_encoder_event_buffer.sv
// Directed self-checking bench for encoder_event_buffer (DEPTH=8, CNT_W=8).
module tb_encoder_event_buffer;

    logic       clk = 1'b0;
    logic       spi_reset_n = 1'b0;
    logic       enc_state_change_stb = 1'b0;
    logic       click = 1'b0;
    logic       clockwise = 1'b0;
    logic       switch = 1'b0;
    logic       event_rd_stb = 1'b0;
    logic       pos_clr_stb = 1'b0;
    logic [7:0] event_reg;
    logic [7:0] position;
    logic [3:0] fifo_level;

    int total = 0;
    int bad   = 0;

    encoder_event_buffer #(
        .DEPTH        (8),
        .CNT_W        (8),
        .ACCEL_WINDOW (100)
    ) dut (
        .clk                  (clk),
        .spi_reset_n          (spi_reset_n),
        .enc_state_change_stb (enc_state_change_stb),
        .click                (click),
        .clockwise            (clockwise),
        .switch               (switch),
        .event_rd_stb         (event_rd_stb),
        .pos_clr_stb          (pos_clr_stb),
        .event_reg            (event_reg),
        .position             (position),
        .fifo_level           (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge.
    task automatic drive(input logic stb, input logic clk_b, input logic cw, input logic sw,
                         input logic rd, input logic clr);
        enc_state_change_stb = stb;
        click                = clk_b;
        clockwise            = cw;
        switch               = sw;
        event_rd_stb         = rd;
        pos_clr_stb          = clr;
        @(posedge clk);
        #1;
        enc_state_change_stb = 1'b0;
        click                = 1'b0;
        clockwise            = 1'b0;
        switch               = 1'b0;
        event_rd_stb         = 1'b0;
        pos_clr_stb          = 1'b0;
    endtask

    task automatic do_reset();
        spi_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        spi_reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [2:0] pat;

    initial begin
        do_reset();
        check("reset_event", 32'(event_reg), 32'h00);
        check("reset_pos", 32'(position), 32'h00);
        check("reset_level", 32'(fifo_level), 32'd0);

`ifdef ENC_ACCEL_EN
        drive(1, 1, 1, 0, 0, 0);
        check("accel_first", 32'(position), 32'd1);
        idle(49);
        drive(1, 1, 1, 0, 0, 0);
        check("accel_fast1", 32'(position), 32'd5);
        idle(49);
        drive(1, 1, 1, 0, 0, 0);
        check("accel_fast2", 32'(position), 32'd9);
        idle(149);
        drive(1, 1, 1, 0, 0, 0);
        check("accel_slow_gap", 32'(position), 32'd10);
        idle(10);
        drive(1, 1, 0, 0, 0, 0);
        check("accel_dir_change", 32'(position), 32'd9);
`else
        // First event and its latency
        drive(1, 1, 1, 0, 0, 0);
        check("first_event", 32'(event_reg), 32'h0B);
        check("first_pos", 32'(position), 32'd1);
        check("first_level", 32'(fifo_level), 32'd1);
        drive(0, 0, 0, 0, 1, 0);
        check("pop_to_empty_event", 32'(event_reg), 32'h03);
        check("pop_to_empty_level", 32'(fifo_level), 32'd0);
        drive(0, 0, 0, 0, 1, 0);
        check("pop_while_empty_level", 32'(fifo_level), 32'd0);

        // Fill with patterns 0..7; clicks net to zero position change
        for (int i = 0; i < 8; i++) begin
            pat = i[2:0];
            drive(1, pat[0], pat[1], pat[2], 0, 0);
        end
        check("fill_level", 32'(fifo_level), 32'd8);
        check("fill_event", 32'(event_reg), 32'h08);
        check("fill_pos", 32'(position), 32'd1);
        drive(1, 1, 0, 1, 0, 0);
        check("overflow_event", 32'(event_reg), 32'h18);
        check("overflow_level", 32'(fifo_level), 32'd8);
        check("overflow_pos", 32'(position), 32'd0);

        for (int k = 1; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            check("drain_event", 32'(event_reg), 32'h08 | 32'(k));
            check("drain_level", 32'(fifo_level), 32'(8 - k));
        end
        drive(0, 0, 0, 0, 1, 0);
        check("drained_event", 32'(event_reg), 32'h07);
        check("drained_level", 32'(fifo_level), 32'd0);

        // Push and pop together at full
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 1, 1, 1, 0);
        check("full_pushpop_level", 32'(fifo_level), 32'd8);
        check("full_pushpop_event", 32'(event_reg), 32'h0C);

        // Reset mid-stream discards everything
        do_reset();
        check("midreset_level", 32'(fifo_level), 32'd0);
        check("midreset_event", 32'(event_reg), 32'h00);

        // Push and pop together at empty
        drive(1, 1, 1, 0, 1, 0);
        check("empty_pushpop_level", 32'(fifo_level), 32'd1);
        check("empty_pushpop_event", 32'(event_reg), 32'h0B);

        // Clear beats a step
        repeat (4) drive(1, 1, 1, 0, 0, 0);
        check("pos_five", 32'(position), 32'd5);
        drive(1, 1, 1, 0, 0, 1);
        check("clear_priority", 32'(position), 32'd0);

        // Saturation both ways
        repeat (130) drive(1, 1, 1, 0, 0, 0);
        check("sat_pos", 32'(position), 32'h7F);
        repeat (260) drive(1, 1, 0, 0, 0, 0);
        check("sat_neg", 32'(position), 32'h80);
        drive(0, 0, 0, 0, 0, 1);
        check("clear_alone", 32'(position), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_event_buffer.md
Name: encoder_event_buffer

Overview:
- Sits directly downstream of the front-panel rotary-encoder decoder. It consumes the decoder's per-event strobe and its click, clockwise and switch qualifiers.
- Queues each event in a small FIFO so the CPU can drain events over SPI without losing any.
- Keeps a saturating signed detent position count.
- Presents a CPU-readable status/event byte plus position and level.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 8, position counter width in bits; signed.
- ACCEL_WINDOW, 250000, clk cycles between clicks that counts as fast rotation; used only with ENC_ACCEL_EN.

Ports:
- clk  in  1  system clock.
- spi_reset_n  in  1  reset; synchronous, active-low.
- enc_state_change_stb  in  1  one-cycle pulse per decoded encoder state change.
- click  in  1  detent reached; qualified by the strobe.
- clockwise  in  1  rotation direction; qualified by the strobe.
- switch  in  1  push-switch level; qualified by the strobe.
- event_rd_stb  in  1  CPU pop of the head event; one-cycle pulse.
- pos_clr_stb  in  1  CPU clear of the position counter.
- event_reg  out  8  [0] click, [1] clockwise, [2] switch, [3] valid (FIFO not empty), [4] overflow (sticky), [7:5] zero.
- position  out  CNT_W  signed detent count.
- fifo_level  out  $clog2(DEPTH)+1  number of queued events.

Behaviour:
- Reset is synchronous: on a clk edge with spi_reset_n=0, all outputs go to 0, the FIFO empties, pointers go to 0 and the overflow flag clears. Reset mid-stream discards all queued events.
- Push: on enc_state_change_stb, the event word {switch, clockwise, click} is written at the tail, if not full.
- Pop: event_rd_stb while not empty advances the head. Pop while empty is ignored.
- Full plus strobe without pop: the new event is dropped and overflow is set to 1.
- Full plus strobe plus pop in the same cycle: both operations occur, level is unchanged and overflow is not set.
- Empty plus strobe plus pop in the same cycle: only the push occurs; level becomes 1.
- Overflow clears on the first pop after it was set, applied in the same cycle as that pop. Clearing has lower priority than a new overflow in the same cycle (set wins).
- event_reg is registered and shows the head entry.
- Latency: a push into an empty FIFO is visible on event_reg, with [3]=1, one clk after the strobe cycle.
- After a pop, the next head appears one clk later. When the FIFO is empty, [2:0] hold their last value and [3]=0.
- fifo_level is registered and updated in the same cycle as event_reg.
- Position step applies only when strobe=1 and click=1: +1 if clockwise, otherwise -1.
- Position saturates at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)); it never wraps.
- pos_clr_stb sets position to 0. If a clear and a step occur in the same cycle, the clear wins and the step is discarded.
- position is registered; it is valid one clk after the strobe.
- Pointer arithmetic is modulo DEPTH, using an extra wrap bit for the full/empty distinction.

Optional Feature:
- Macro ENC_ACCEL_EN.
- When defined:
  - A cycle timer restarts on every click.
  - If a click arrives with the timer below ACCEL_WINDOW and in the same direction as the previous click, the step magnitude is 4 instead of 1.
  - Saturation still applies. The timer saturates at ACCEL_WINDOW and clears on reset.
  - The first click after reset always steps by 1.
- When undefined: the step is always 1, and there is no timer logic or ACCEL_WINDOW usage; the parameter remains but is unused.

Decomposition:
- Package front_panel_pkg holds:
  - the enc_event_t packed struct {switch, clockwise, click};
  - bit-index constants EVT_CLICK=0, EVT_CW=1, EVT_SW=2, EVT_VALID=3, EVT_OVF=4;
  - the step constants STEP_SLOW=1 and STEP_FAST=4.
- One sub-module, enc_event_fifo: a synchronous FIFO with push, pop, full, empty and level outputs, parameterised by DEPTH and data width.
- The position counter and the optional acceleration logic stay in the top module.

Test Plan:
- Reset/first event: reset, then one strobe with click=1, cw=1, sw=0 -> event_reg=8'h0B one clk later; position=1; fifo_level=1.
- FIFO fill: 8 strobes without pops -> level=8; ninth strobe -> level=8 and event_reg[4]=1. Popping all 8 -> the first pop clears overflow, the entries come out in FIFO order, and the final state is event_reg[3]=0 with level=0.
- Simultaneous push and pop: at full, apply strobe and pop together -> level stays 8 and overflow stays 0. At empty, apply both together -> level=1.
- Saturation (CNT_W=8): 130 CW clicks -> position=127; then 260 CCW clicks -> position=-128.
- Clear priority: pos_clr_stb and a CW click in the same cycle with position=5 -> position=0.
- ENC_ACCEL_EN with ACCEL_WINDOW=100: CW clicks 50 cycles apart -> steps 1, 4, 4. A gap of 150 cycles then a click -> step 1. A CCW click within the window after CW -> step -1.
